nes_mem_sched: RTL

Memory-slot scheduler between the NES core, the game loader and the single SDRAM port. Generates the 4-phase CPU/PPU enable sequence and the SDRAM `clkref`. Buffers loader bytes in a small FIFO and commits them one per NES slot. Holds the NES in reset until every downloaded byte has reached SDRAM.

---
 rtl/nes_mem_sched.sv | 108 ++++++++++
 1 files changed

// File: rtl/nes_mem_sched.sv
// nes_mem_sched: NES/loader/SDRAM slot scheduler with loader FIFO and NES reset hold
//   in : clk, nreset (sync, active-low), downloading, ext_reset,
//        ld_wr/ld_addr/ld_data (loader byte), nes_addr/nes_write/nes_dout (NES access)
//   out: phase/clkref (slot timing), run_nes/reset_nes (NES control),
//        mem_addr/mem_din/mem_we (SDRAM port), ld_count/ld_overflow (FIFO status)
module nes_mem_sched #(
  parameter int AW    = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     downloading,
  input  logic                     ext_reset,
  input  logic                     ld_wr,
  input  logic [AW-1:0]            ld_addr,
  input  logic [7:0]               ld_data,
  input  logic [AW-1:0]            nes_addr,
  input  logic                     nes_write,
  input  logic [7:0]               nes_dout,
  output logic [1:0]               phase,
  output logic                     clkref,
  output logic                     run_nes,
  output logic                     reset_nes,
  output logic [AW-1:0]            mem_addr,
  output logic [7:0]               mem_din,
  output logic                     mem_we,
  output logic [$clog2(DEPTH):0]   ld_count,
  output logic                     ld_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic            armed_q, armed_d, ovf_q, ovf_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [AW+7:0]   fifo_q [DEPTH];
  logic [AW+7:0]   fifo_d [DEPTH];
  logic            p3, pop, push, to_load;
  always_comb begin
    p3      = phase_q == 2'd3;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
    pop     = p3 && cnt_q != '0 && state_q != RUN;
    push    = ld_wr && (cnt_q != FULL || pop);
    phase_d = phase_q + 2'd1;
    wp_d    = push ? wp_q + PW'(1) : wp_q;
    rp_d    = pop ? rp_q + PW'(1) : rp_q;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    fifo_d  = fifo_q;
    if (push) fifo_d[wp_q] = {ld_addr, ld_data};
    state_d = state_q;
    to_load = 1'b0;
    if (state_q != LOAD && downloading) begin
      state_d = LOAD;
      to_load = 1'b1;
    end else if (state_q == LOAD && !downloading) begin
      state_d = DRAIN;
    end else if (state_q == DRAIN && p3 && cnt_q == '0 && !we_q) begin
      state_d = RUN;
    end
    ovf_d   = (ovf_q && !to_load) || (ld_wr && !push);
    armed_d = armed_q || downloading;
    // Commit window spans exactly one slot: set/cleared only at phase 3.
    we_d    = p3 ? pop : we_q;
    addr_d  = pop ? fifo_q[rp_q][AW+7:8] : addr_q;
    data_d  = pop ? fifo_q[rp_q][7:0] : data_q;
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= RUN;
      phase_q <= '0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) fifo_q <= fifo_d;
  always_comb begin
    phase       = phase_q;
    clkref      = phase_q[1];
    reset_nes   = ext_reset || state_q != RUN || !armed_q;
    run_nes     = p3 && !reset_nes;
    mem_addr    = state_q != RUN ? addr_q : nes_addr;
    mem_din     = state_q != RUN ? data_q : nes_dout;
    mem_we      = we_q || (nes_write && state_q == RUN);
    ld_count    = cnt_q;
    ld_overflow = ovf_q;
  end
endmodule
